// File: rtl/result_uart_drain.sv
// Streams the systolic array's result banks out through a byte-wide UART:
// header byte, every bank word LSB first, then an XOR checksum byte.
module result_uart_drain #(
   parameter int          N   = 2,
   parameter int          AW  = 11,
   parameter logic [7:0]  HDR = 8'hA5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [AW-1:0]       word_cnt,
   output logic                busy,
   output logic                done,
   output logic [AW-1:0]       ram_c_addr,
   output logic [N*N-1:0]      ram_c_rden,
   input  logic [32*N*N-1:0]   ram_c_q,
   output logic [7:0]          uart_tx_data,
   output logic                uart_send_data,
   input  logic                uart_tx_done
);

   localparam int NN = N * N;
   localparam int BW = (NN > 1) ? $clog2(NN) : 1;

   typedef enum logic [3:0] {
      ST_IDLE, ST_HDR, ST_RD, ST_RDW, ST_LOAD, ST_SEND, ST_WAITTX, ST_CKS, ST_FIN
   } state_t;

   state_t         state_reg, state_next;
   logic [AW-1:0]  cnt_reg, cnt_next;
   logic [AW:0]    addr_reg, addr_next;
   logic [BW-1:0]  bank_reg, bank_next;
   logic [1:0]     byte_reg, byte_next;
   logic [31:0]    shreg_reg, shreg_next;
   logic [7:0]     cks_reg, cks_next;
   logic [7:0]     tx_data_reg;
   logic           sent_reg, sent_next;
   logic [AW:0]    addr_inc;

   assign addr_inc = addr_reg + (AW+1)'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= ST_IDLE;
         cnt_reg     <= '0;
         addr_reg    <= '0;
         bank_reg    <= '0;
         byte_reg    <= '0;
         shreg_reg   <= '0;
         cks_reg     <= '0;
         tx_data_reg <= '0;
         sent_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         addr_reg    <= addr_next;
         bank_reg    <= bank_next;
         byte_reg    <= byte_next;
         shreg_reg   <= shreg_next;
         cks_reg     <= cks_next;
         tx_data_reg <= uart_tx_data;
         sent_reg    <= sent_next;
      end
   end

   // HDR and CKS each use sent_reg to split "pulse once" from "wait for tx_done".
   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      addr_next      = addr_reg;
      bank_next      = bank_reg;
      byte_next      = byte_reg;
      shreg_next     = shreg_reg;
      cks_next       = cks_reg;
      sent_next      = sent_reg;
      uart_send_data = 1'b0;
      uart_tx_data   = tx_data_reg;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               cnt_next   = word_cnt;
               addr_next  = '0;
               bank_next  = '0;
               byte_next  = '0;
               cks_next   = '0;
               sent_next  = 1'b0;
               state_next = ST_HDR;
            end
         end
         ST_HDR: begin
            if (!sent_reg) begin
               uart_send_data = 1'b1;
               uart_tx_data   = HDR;
               sent_next      = 1'b1;
            end else if (uart_tx_done) begin
               sent_next  = 1'b0;
               state_next = (cnt_reg == '0) ? ST_CKS : ST_RD;
            end
         end
         ST_RD:   state_next = ST_RDW;
         ST_RDW:  state_next = ST_LOAD;
         ST_LOAD: begin
            shreg_next = ram_c_q[32*int'(bank_reg) +: 32];
            state_next = ST_SEND;
         end
         ST_SEND: begin
            uart_send_data = 1'b1;
            uart_tx_data   = shreg_reg[7:0];
            state_next     = ST_WAITTX;
         end
         ST_WAITTX: begin
            if (uart_tx_done) begin
               shreg_next = {8'h00, shreg_reg[31:8]};
               cks_next   = cks_reg ^ shreg_reg[7:0];
               if (byte_reg == 2'd3) begin
                  byte_next = '0;
                  if (bank_reg == BW'(NN-1)) begin
                     bank_next  = '0;
                     addr_next  = addr_inc;
                     state_next = (addr_inc == {1'b0, cnt_reg}) ? ST_CKS : ST_RD;
                  end else begin
                     bank_next  = bank_reg + BW'(1);
                     state_next = ST_RD;
                  end
               end else begin
                  byte_next  = byte_reg + 2'd1;
                  state_next = ST_SEND;
               end
            end
         end
         ST_CKS: begin
            if (!sent_reg) begin
               uart_send_data = 1'b1;
               uart_tx_data   = cks_reg;
               sent_next      = 1'b1;
            end else if (uart_tx_done) begin
               sent_next  = 1'b0;
               state_next = ST_FIN;
            end
         end
         ST_FIN:  state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   generate
      for (genvar gi = 0; gi < NN; gi++) begin : g_rden
         assign ram_c_rden[gi] = (state_reg == ST_RD) && (bank_reg == BW'(gi));
      end
   endgenerate

   assign ram_c_addr = addr_reg[AW-1:0];
   assign busy       = (state_reg != ST_IDLE) && (state_reg != ST_FIN);
   assign done       = (state_reg == ST_FIN);

endmodule

// File: tb/tb_result_uart_drain.sv
// Scoreboard bench for result_uart_drain: a frame model queues expected bytes
// and RAM reads, a negedge monitor pops and compares them.
module tb_result_uart_drain;
   localparam int N  = 2;
   localparam int NN = N * N;
   localparam int AW = 11;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            start = 1'b0;
   logic [AW-1:0]   word_cnt = '0;
   logic            busy, done;
   logic [AW-1:0]   ram_c_addr;
   logic [NN-1:0]   ram_c_rden;
   logic [32*NN-1:0] ram_c_q = '0;
   logic [7:0]      uart_tx_data;
   logic            uart_send_data;
   logic            uart_tx_done = 1'b0;

   logic [31:0] mem [NN][1 << AW];
   int exp_q[$];
   int rd_q[$];
   int n_pass = 0, n_total = 0;
   int done_seen = 0, sent_cnt = 0;
   int uart_gen = 0, uart_dmax = 1;
   int last_byte = 0;
   bit mon_en = 1'b0;

   result_uart_drain #(.N(N), .AW(AW), .HDR(8'hA5)) dut (
      .clk(clk), .rst(rst), .start(start), .word_cnt(word_cnt),
      .busy(busy), .done(done), .ram_c_addr(ram_c_addr), .ram_c_rden(ram_c_rden),
      .ram_c_q(ram_c_q), .uart_tx_data(uart_tx_data), .uart_send_data(uart_send_data),
      .uart_tx_done(uart_tx_done)
   );

   always #5 clk = ~clk;

   // Result RAM with one cycle of read latency; q holds while rden is low.
   always @(posedge clk) begin
      for (int k = 0; k < NN; k++)
         if (ram_c_rden[k]) ram_c_q[32*k +: 32] <= mem[k][ram_c_addr];
   end

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   // UART: answers each send pulse with a tx_done after 1..uart_dmax cycles.
   initial begin
      forever begin
         @(negedge clk);
         if (uart_send_data) begin
            int g, d;
            g = uart_gen;
            d = $urandom_range(uart_dmax, 1);
            repeat (d) @(posedge clk);
            #1;
            if (g == uart_gen) begin
               uart_tx_done = 1'b1;
               @(posedge clk);
               #1 uart_tx_done = 1'b0;
            end
         end
      end
   end

   // Monitor: bytes, reads, held tx_data and done pulses.
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (uart_send_data) begin
               int e;
               e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
               chk("byte", int'(uart_tx_data), e);
               sent_cnt++;
               last_byte = int'(uart_tx_data);
            end else begin
               chk("tx_hold", int'(uart_tx_data), last_byte);
            end
            if (ram_c_rden != '0) begin
               int e, er;
               e  = (rd_q.size() > 0) ? rd_q.pop_front() : -1;
               er = (e < 0) ? 0 : (1 << (e % NN));
               chk("rden", int'(ram_c_rden), er);
               if (e >= 0) chk("rd_addr", int'(ram_c_addr), e / NN);
            end
            if (done) begin
               done_seen++;
               chk("busy_at_done", int'(busy), 0);
               chk("bytes_before_done", exp_q.size(), 0);
            end
         end
      end
   end

   // Reference frame: header, bank words LSB first per address, XOR checksum.
   task automatic model_frame(input int wc);
      logic [7:0] cks, b;
      cks = 8'h00;
      exp_q.push_back(8'hA5);
      for (int a = 0; a < wc; a++)
         for (int k = 0; k < NN; k++) begin
            rd_q.push_back(a * NN + k);
            for (int i = 0; i < 4; i++) begin
               b = mem[k][a][8*i +: 8];
               cks ^= b;
               exp_q.push_back(int'(b));
            end
         end
      exp_q.push_back(int'(cks));
   endtask

   task automatic fill_random(input int wc);
      for (int a = 0; a < wc; a++)
         for (int k = 0; k < NN; k++) mem[k][a] = $urandom;
   endtask

   task automatic pulse_start(input int wc);
      @(posedge clk); #1;
      start = 1'b1; word_cnt = AW'(wc);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic run_frame(input int wc, input bit poke);
      int d0, s0, cyc;
      d0 = done_seen;
      s0 = sent_cnt;
      model_frame(wc);
      pulse_start(wc);
      if (poke) begin
         cyc = 0;
         while (ram_c_rden == '0 && cyc < 400) begin @(negedge clk); cyc++; end
         chk("reached_rd", int'(ram_c_rden != '0), 1);
         uart_tx_done = 1'b1;
         start = 1'b1; word_cnt = AW'(5);
         @(posedge clk); #1;
         uart_tx_done = 1'b0;
         start = 1'b0;
      end
      cyc = 0;
      while (done_seen == d0 && cyc < 5000) begin @(posedge clk); cyc++; end
      repeat (30) @(posedge clk);
      #1;
      chk("done_count", done_seen, d0 + 1);
      chk("idle_after", int'(busy), 0);
      chk("bytes_left", exp_q.size(), 0);
      chk("reads_left", rd_q.size(), 0);
      chk("frame_len", sent_cnt - s0, 2 + 4 * NN * wc);
      $display("frame word_cnt=%0d bytes=%0d dones=%0d", wc, sent_cnt - s0, done_seen - d0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_send", int'(uart_send_data), 0);
      chk("rst_rden", int'(ram_c_rden), 0);
      chk("rst_addr", int'(ram_c_addr), 0);
      chk("rst_txdata", int'(uart_tx_data), 0);
      mon_en = 1'b1;

      // Known-data frame; its checksum is 00.
      mem[0][0] = 32'h11223344; mem[1][0] = 32'h55667788;
      mem[2][0] = 32'h99AABBCC; mem[3][0] = 32'hDDEEFF00;
      uart_dmax = 1;
      run_frame(1, 1'b0);

      run_frame(0, 1'b0);

      uart_dmax = 20;
      fill_random(3);
      run_frame(3, 1'b0);

      fill_random(2);
      run_frame(2, 1'b1);

      // Abort a frame with reset after its 8th byte, then run it cleanly.
      begin
         int d0, s0, cyc;
         uart_dmax = 4;
         fill_random(2);
         d0 = done_seen;
         s0 = sent_cnt;
         model_frame(2);
         pulse_start(2);
         cyc = 0;
         while (sent_cnt < s0 + 8 && cyc < 2000) begin @(negedge clk); cyc++; end
         chk("bytes_before_rst", sent_cnt - s0, 8);
         @(posedge clk); #1;
         rst = 1'b1;
         mon_en = 1'b0;
         uart_gen++;
         exp_q.delete();
         rd_q.delete();
         @(posedge clk); #1;
         rst = 1'b0;
         uart_tx_done = 1'b1;
         last_byte = 0;
         @(negedge clk);
         chk("abort_busy", int'(busy), 0);
         chk("abort_done", int'(done), 0);
         chk("abort_send", int'(uart_send_data), 0);
         chk("abort_rden", int'(ram_c_rden), 0);
         chk("abort_addr", int'(ram_c_addr), 0);
         chk("abort_txdata", int'(uart_tx_data), 0);
         mon_en = 1'b1;
         @(posedge clk); #1;
         uart_tx_done = 1'b0;
         repeat (40) @(posedge clk);
         #1;
         chk("no_done_after_abort", done_seen, d0);
         chk("idle_after_abort", int'(busy), 0);
         $display("frame word_cnt=2 aborted after %0d bytes", sent_cnt - s0);
      end
      run_frame(2, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
